// File: rtl/ripple_sync_cmp.sv
// ripple_sync_cmp: binary counter vs. synchronous ripple-counter emulation with a lag-aware equivalence checker (optional fault port via CNT_FAULT_INJECT_EN)
module ripple_sync_cmp #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef CNT_FAULT_INJECT_EN
  input  logic             fault_inj,
`endif
  output logic [WIDTH-1:0] count_a,
  output logic [WIDTH-1:0] count_b,
  output logic             match,
  output logic             mismatch_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             settled
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDLE_MAX = IW'(WIDTH - 1);
  logic [WIDTH-1:0] prev_b, exp_b, b_tog;
  logic [WIDTH-1:0] hist [1:WIDTH-1];
  logic [IW-1:0] idle;
  logic fault;
`ifdef CNT_FAULT_INJECT_EN
  assign fault = fault_inj;
`else
  assign fault = 1'b0;
  // without a fault source the ripple chain must always agree with the lag model
  a_match: assert property (@(posedge clk) disable iff (rst) match);
`endif
  assign exp_b[0] = count_a[0];
  assign b_tog[0] = en ^ fault;
  // stage i toggles one cycle after stage i-1 is seen falling
  for (genvar i = 1; i < WIDTH; i++) begin : g_stage
    assign exp_b[i] = hist[i][i];
    assign b_tog[i] = prev_b[i-1] & ~count_b[i-1];
  end
  assign match = (count_b == exp_b);
  assign settled = (idle == IDLE_MAX);
  always_ff @(posedge clk) begin
    if (rst) begin
      count_a <= '0;
      count_b <= '0;
      prev_b <= '0;
      for (int k = 1; k < WIDTH; k++) hist[k] <= '0;
      mismatch_sticky <= 1'b0;
      err_cnt <= '0;
      idle <= IDLE_MAX;
    end else begin
      count_a <= count_a + WIDTH'(en);
      count_b <= count_b ^ b_tog;
      prev_b <= count_b;
      hist[1] <= count_a;
      for (int k = 2; k < WIDTH; k++) hist[k] <= hist[k-1];
      mismatch_sticky <= mismatch_sticky | ~match;
      err_cnt <= err_cnt + ERR_W'(!match && err_cnt != '1);
      idle <= en ? '0 : idle + IW'(idle != IDLE_MAX);
    end
  end
endmodule

// File: tb/tb_ripple_sync_cmp.sv
// tb_ripple_sync_cmp: scoreboard bench comparing the DUT against a history-based lag model
module tb_ripple_sync_cmp;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, fault_inj = 1'b0;
  logic [3:0] count_a, count_b;
  logic match, mismatch_sticky, settled;
  logic [7:0] err_cnt;
  int checks = 0, errors = 0;

  typedef struct {
    logic [3:0] a, b;
    logic       m, s, st;
    logic [7:0] e;
  } exp_t;
  exp_t sb[$];

  int ma = 0, midle = 3;
  logic [3:0] mh [4];

  ripple_sync_cmp #(.WIDTH(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef CNT_FAULT_INJECT_EN
    .fault_inj(fault_inj),
`endif
    .count_a(count_a), .count_b(count_b), .match(match),
    .mismatch_sticky(mismatch_sticky), .err_cnt(err_cnt), .settled(settled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // drive one cycle, advance the model, queue its prediction, then compare after the edge
  task automatic step(input logic e, input logic r);
    exp_t x;
    logic [3:0] eb;
    en = e;
    rst = r;
    if (r) begin
      ma = 0;
      for (int k = 0; k < 4; k++) mh[k] = 4'd0;
      midle = 3;
    end else begin
      ma = (ma + int'(e)) % 16;
      for (int k = 3; k > 0; k--) mh[k] = mh[k-1];
      mh[0] = 4'(ma);
      midle = e ? 0 : (midle < 3 ? midle + 1 : 3);
    end
    for (int i = 0; i < 4; i++) eb[i] = mh[i][i];
    sb.push_back('{a: 4'(ma), b: eb, m: 1'b1, s: (midle == 3), st: 1'b0, e: 8'd0});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("count_a", 32'(count_a), 32'(x.a));
    chk("count_b", 32'(count_b), 32'(x.b));
    chk("match", 32'(match), 32'(x.m));
    chk("settled", 32'(settled), 32'(x.s));
    chk("sticky", 32'(mismatch_sticky), 32'(x.st));
    chk("err_cnt", 32'(err_cnt), 32'(x.e));
  endtask

  initial begin
    int rp0, rp1, rp2;
    // reset, then a full enabled lap including the 15 -> 0 wrap
    step(0, 1);
    repeat (16) step(1, 0);
    // stop at 8 and let the cascade settle
    step(0, 1);
    repeat (8) step(1, 0);
    repeat (5) step(0, 0);
    // wrap cascade 15 -> 0 observed with en low
    step(0, 1);
    repeat (16) step(1, 0);
    repeat (5) step(0, 0);
    // reset in the middle of a cascade, then watch for residual toggles
    step(0, 1);
    repeat (12) step(1, 0);
    step(1, 1);
    repeat (6) step(0, 0);
    // en toggled while cascades are in flight
    repeat (8) step(1, 0);
    repeat (3) begin
      step(0, 0);
      step(1, 0);
    end
    // random en with three random reset pulses
    rp0 = $urandom_range(20, 160);
    rp1 = $urandom_range(180, 330);
    rp2 = $urandom_range(350, 490);
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), (i == rp0) || (i == rp1) || (i == rp2));
`ifdef CNT_FAULT_INJECT_EN
    step(0, 1);
    repeat (5) step(1, 0);
    fault_inj = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    fault_inj = 1'b0;
    chk("fault_match", 32'(match), 32'd0);
    chk("fault_sticky_early", 32'(mismatch_sticky), 32'd0);
    @(posedge clk);
    #1;
    chk("fault_sticky", 32'(mismatch_sticky), 32'd1);
    chk("fault_err1", 32'(err_cnt), 32'd1);
    repeat (300) @(posedge clk);
    #1;
    chk("fault_err_sat", 32'(err_cnt), 32'd255);
    chk("fault_match_hold", 32'(match), 32'd0);
    step(0, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
